pb_job_sched: RTL and testbench
===============================

// Module: pb_job_sched
// PURPOSE
//  Round-robin scheduler sharing one packet builder (pb) between NUM_REQ job requesters.
//  Accepts one build descriptor at a time and drives the pb config/regs interface.
//  Pulses pb_start, waits for pb_irq, then reports completion to the owning requester.
//  Sits between the requester masters and the pb_regs_port side of the packet builder.
// PARAMETERS
//  NUM_REQ    2    number of requesters (2..8); requester id width ID_W = $clog2(NUM_REQ)
//  TIMEOUT    255  watchdog limit in cycles spent in WAIT_IRQ (only with PB_SCHED_TIMEOUT_EN)
// PORTS
//  clk            in   1          clock
//  reset          in   1          synchronous, active-high reset
//  sched_en       in   1          low: no new grants; an in-flight job still completes
//  req_valid      in   NUM_REQ    per-requester descriptor valid
//  req_ready      out  NUM_REQ    per-requester accept, one-hot or zero
//  req_addr_in    in   NUM_REQ*32 source address in inmem, slice i for requester i
//  req_addr_out   in   NUM_REQ*32 destination address in outmem
//  req_byte_cnt   in   NUM_REQ*4  payload byte count field
//  req_data_sel   in   NUM_REQ*4  data packing select (legal 0,1,2)
//  req_crc_en     in   NUM_REQ    1: pb computes CRC; 0: use crc_val
//  req_crc_val    in   NUM_REQ*8  predefined CRC value
//  pb_start       out  1          one-cycle start pulse to pb
//  pb_addr_in     out  32         latched descriptor fields to pb, stable from accept to next accept
//  pb_addr_out    out  32         "
//  pb_byte_cnt    out  4          "
//  pb_data_sel    out  4          "
//  pb_crc_en      out  1          "
//  pb_crc_val     out  8          "
//  pb_irq         in   1          pb job-complete indication
//  done_valid     out  1          one-cycle completion pulse
//  done_id        out  ID_W       requester id of completed job, held until next done
//  done_err       out  1          illegal data_sel; job not started. Qualified by done_valid
//  done_timeout   out  1          watchdog expiry. Qualified by done_valid
//  busy           out  1          high in every state except IDLE
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, rr_ptr = NUM_REQ-1 so requester 0 wins first. Reset mid-job aborts.
//  FSM: IDLE -> START -> WAIT_IRQ -> DONE -> IDLE. IDLE -> DONE on illegal data_sel.
//  IDLE: if sched_en and any req_valid, grant the first valid index searching rr_ptr+1 .. rr_ptr,
//   modulo NUM_REQ. req_ready[g] = 1 combinationally in that cycle.
//   Capture slice g into the pb_* registers; rr_ptr <= g; done_id <= g.
//   Next state: START; DONE with err if data_sel > 2.
//  Requesters hold valid and fields stable until ready. A drop of valid before ready is legal; no grant results.
//  START: pb_start = 1 for exactly this cycle; pb_* match the captured values; clear watchdog; -> WAIT_IRQ.
//  WAIT_IRQ: stay until pb_irq = 1, then -> DONE. pb_irq outside WAIT_IRQ is ignored.
//  DONE: done_valid = 1 for one cycle, plus done_err / done_timeout as applicable; -> IDLE.
//   No grant is made in the DONE cycle.
//  Latency: accept (cycle N) -> pb_start at N+1. pb_irq at cycle M -> done_valid at M+1.
//   Minimum back-to-back accept spacing is 4 cycles.
//  pb_* outputs never change except on an accept cycle.
//  sched_en deasserting mid-job has no effect until IDLE.
// CONFIGURATION
//  PB_SCHED_TIMEOUT_EN defined:
//   - 8-bit watchdog increments each WAIT_IRQ cycle.
//   - On reaching TIMEOUT without pb_irq: -> DONE with done_timeout = 1.
//   - pb_irq arriving on the expiry cycle wins: done_timeout = 0.
//  PB_SCHED_TIMEOUT_EN undefined:
//   - No counter; WAIT_IRQ waits indefinitely.
//   - done_timeout tied to 0.
// TESTING
//  1. Single job: req0 valid, addr_in=0x10, data_sel=2, byte_cnt=5 -> ready0 at cycle 0;
//     pb_start at 1 with pb_addr_in=0x10; pb_irq at 6 -> done_valid at 7, done_id=0.
//  2. Both valid continuously, 3 jobs -> grants 0,1,0. Each pb_start is preceded by its own accept.
//  3. req1 data_sel=4 -> ready1, then done_valid with done_err=1 on the next cycle; pb_start never pulses.
//  4. sched_en=0 with req0 valid -> no ready for 10 cycles. sched_en=1 -> grant on the same cycle.
//  5. Reset asserted in WAIT_IRQ -> next cycle IDLE, busy=0, outputs 0; next grant goes to req0.
//  6. With PB_SCHED_TIMEOUT_EN and TIMEOUT=20, pb_irq never arrives -> done_valid with done_timeout=1
//     after 20 WAIT_IRQ cycles.

Source files
------------

// File: rtl/pb_job_sched.sv
// rtl/pb_job_sched.sv - round-robin job scheduler for one shared packet builder (optional watchdog: PB_SCHED_TIMEOUT_EN)
module pb_job_sched #(
    parameter  int NUM_REQ = 2,
    parameter  int TIMEOUT = 255,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_sched_en,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    output logic [NUM_REQ-1:0]     o_req_ready,
    input  logic [NUM_REQ*32-1:0]  i_req_addr_in,
    input  logic [NUM_REQ*32-1:0]  i_req_addr_out,
    input  logic [NUM_REQ*4-1:0]   i_req_byte_cnt,
    input  logic [NUM_REQ*4-1:0]   i_req_data_sel,
    input  logic [NUM_REQ-1:0]     i_req_crc_en,
    input  logic [NUM_REQ*8-1:0]   i_req_crc_val,
    output logic                   o_pb_start,
    output logic [31:0]            o_pb_addr_in,
    output logic [31:0]            o_pb_addr_out,
    output logic [3:0]             o_pb_byte_cnt,
    output logic [3:0]             o_pb_data_sel,
    output logic                   o_pb_crc_en,
    output logic [7:0]             o_pb_crc_val,
    input  logic                   i_pb_irq,
    output logic                   o_done_valid,
    output logic [ID_W-1:0]        o_done_id,
    output logic                   o_done_err,
    output logic                   o_done_timeout,
    output logic                   o_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_IRQ,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic              r_pb_start;
    logic [31:0]       r_pb_addr_in;
    logic [31:0]       r_pb_addr_out;
    logic [3:0]        r_pb_byte_cnt;
    logic [3:0]        r_pb_data_sel;
    logic              r_pb_crc_en;
    logic [7:0]        r_pb_crc_val;
    logic              r_done_valid;
    logic [ID_W-1:0]   r_done_id;
    logic              r_done_err;
    logic              r_done_timeout;
    logic              r_busy;
`ifdef PB_SCHED_TIMEOUT_EN
    logic [7:0]        r_wdog;
`endif

    logic [NUM_REQ-1:0] w_rot;
    logic               w_found;
    logic [ID_W-1:0]    w_grant_id;
    logic               w_accept;
    logic               w_illegal;
    logic [31:0]        w_addr_in;
    logic [31:0]        w_addr_out;
    logic [3:0]         w_byte_cnt;
    logic [3:0]         w_data_sel;
    logic               w_crc_en;
    logic [7:0]         w_crc_val;

    // Round-robin search: rotate valids so bit 0 is the requester after rr_ptr, lowest set bit wins
    always_comb begin
        int v_sh;
        int v_sum;
        v_sh = int'(r_rr_ptr) + 1;
        if (v_sh >= NUM_REQ) v_sh = 0;
        w_rot   = NUM_REQ'({i_req_valid, i_req_valid} >> v_sh);
        w_found = 1'b0;
        v_sum   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                v_sum   = v_sh + k;
            end
        end
        if (v_sum >= NUM_REQ) v_sum = v_sum - NUM_REQ;
        w_grant_id = ID_W'(v_sum);
    end

    // Select the granted requester's descriptor slice
    always_comb begin
        w_addr_in  = '0;
        w_addr_out = '0;
        w_byte_cnt = '0;
        w_data_sel = '0;
        w_crc_en   = 1'b0;
        w_crc_val  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_id == ID_W'(i)) begin
                w_addr_in  = i_req_addr_in[i*32 +: 32];
                w_addr_out = i_req_addr_out[i*32 +: 32];
                w_byte_cnt = i_req_byte_cnt[i*4 +: 4];
                w_data_sel = i_req_data_sel[i*4 +: 4];
                w_crc_en   = i_req_crc_en[i];
                w_crc_val  = i_req_crc_val[i*8 +: 8];
            end
        end
    end

    assign w_accept    = (r_state == S_IDLE) && i_sched_en && w_found;
    assign w_illegal   = (w_data_sel > 4'd2);
    assign o_req_ready = w_accept ? (NUM_REQ'(1) << w_grant_id) : '0;

    // Scheduler FSM with registered pb and completion outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_rr_ptr       <= ID_W'(NUM_REQ - 1);
            r_pb_start     <= 1'b0;
            r_pb_addr_in   <= '0;
            r_pb_addr_out  <= '0;
            r_pb_byte_cnt  <= '0;
            r_pb_data_sel  <= '0;
            r_pb_crc_en    <= 1'b0;
            r_pb_crc_val   <= '0;
            r_done_valid   <= 1'b0;
            r_done_id      <= '0;
            r_done_err     <= 1'b0;
            r_done_timeout <= 1'b0;
            r_busy         <= 1'b0;
`ifdef PB_SCHED_TIMEOUT_EN
            r_wdog         <= '0;
`endif
        end else begin
            r_pb_start     <= 1'b0;
            r_done_valid   <= 1'b0;
            r_done_err     <= 1'b0;
            r_done_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_pb_addr_in  <= w_addr_in;
                        r_pb_addr_out <= w_addr_out;
                        r_pb_byte_cnt <= w_byte_cnt;
                        r_pb_data_sel <= w_data_sel;
                        r_pb_crc_en   <= w_crc_en;
                        r_pb_crc_val  <= w_crc_val;
                        r_rr_ptr      <= w_grant_id;
                        r_done_id     <= w_grant_id;
                        r_busy        <= 1'b1;
                        if (w_illegal) begin
                            // Bad packing select: report the error without starting the pb
                            r_state      <= S_DONE;
                            r_done_valid <= 1'b1;
                            r_done_err   <= 1'b1;
                        end else begin
                            r_state    <= S_START;
                            r_pb_start <= 1'b1;
                        end
                    end
                end
                S_START: begin
`ifdef PB_SCHED_TIMEOUT_EN
                    r_wdog  <= '0;
`endif
                    r_state <= S_WAIT_IRQ;
                end
                S_WAIT_IRQ: begin
                    if (i_pb_irq) begin
                        r_state      <= S_DONE;
                        r_done_valid <= 1'b1;
`ifdef PB_SCHED_TIMEOUT_EN
                    end else if (({1'b0, r_wdog} + 9'd1) == 9'(TIMEOUT)) begin
                        r_state        <= S_DONE;
                        r_done_valid   <= 1'b1;
                        r_done_timeout <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + 8'd1;
`endif
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifndef PB_SCHED_TIMEOUT_EN
    logic w_unused_timeout;
    assign w_unused_timeout = ^8'(TIMEOUT);
`endif

    assign o_pb_start     = r_pb_start;
    assign o_pb_addr_in   = r_pb_addr_in;
    assign o_pb_addr_out  = r_pb_addr_out;
    assign o_pb_byte_cnt  = r_pb_byte_cnt;
    assign o_pb_data_sel  = r_pb_data_sel;
    assign o_pb_crc_en    = r_pb_crc_en;
    assign o_pb_crc_val   = r_pb_crc_val;
    assign o_done_valid   = r_done_valid;
    assign o_done_id      = r_done_id;
    assign o_done_err     = r_done_err;
    assign o_done_timeout = r_done_timeout;
    assign o_busy         = r_busy;

endmodule

// File: tb/tb_pb_job_sched.sv
// tb/tb_pb_job_sched.sv - directed self-checking bench for pb_job_sched
module tb_pb_job_sched;

    logic        clk;
    logic        reset;
    logic        sched_en;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_addr_in;
    logic [63:0] req_addr_out;
    logic [7:0]  req_byte_cnt;
    logic [7:0]  req_data_sel;
    logic [1:0]  req_crc_en;
    logic [15:0] req_crc_val;
    logic        pb_start;
    logic [31:0] pb_addr_in;
    logic [31:0] pb_addr_out;
    logic [3:0]  pb_byte_cnt;
    logic [3:0]  pb_data_sel;
    logic        pb_crc_en;
    logic [7:0]  pb_crc_val;
    logic        pb_irq;
    logic        done_valid;
    logic [0:0]  done_id;
    logic        done_err;
    logic        done_timeout;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    pb_job_sched #(.NUM_REQ(2), .TIMEOUT(20)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_sched_en     (sched_en),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_addr_in  (req_addr_in),
        .i_req_addr_out (req_addr_out),
        .i_req_byte_cnt (req_byte_cnt),
        .i_req_data_sel (req_data_sel),
        .i_req_crc_en   (req_crc_en),
        .i_req_crc_val  (req_crc_val),
        .o_pb_start     (pb_start),
        .o_pb_addr_in   (pb_addr_in),
        .o_pb_addr_out  (pb_addr_out),
        .o_pb_byte_cnt  (pb_byte_cnt),
        .o_pb_data_sel  (pb_data_sel),
        .o_pb_crc_en    (pb_crc_en),
        .o_pb_crc_val   (pb_crc_val),
        .i_pb_irq       (pb_irq),
        .o_done_valid   (done_valid),
        .o_done_id      (done_id),
        .o_done_err     (done_err),
        .o_done_timeout (done_timeout),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

    task automatic step;
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int g;
        reset        = 1'b1;
        sched_en     = 1'b0;
        req_valid    = '0;
        req_addr_in  = '0;
        req_addr_out = '0;
        req_byte_cnt = '0;
        req_data_sel = '0;
        req_crc_en   = '0;
        req_crc_val  = '0;
        pb_irq       = 1'b0;
        step;
        step;

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_pb_start", pb_start, 0);
        check("rst_done_valid", done_valid, 0);
        check("rst_pb_addr_in", pb_addr_in, 0);
        check("rst_done_id", done_id, 0);
        check("rst_ready", req_ready, 0);
        reset = 1'b0;

        // Single job on requester 0
        step;
        sched_en           = 1'b1;
        req_valid          = 2'b01;
        req_addr_in[31:0]  = 32'h10;
        req_addr_out[31:0] = 32'h200;
        req_byte_cnt[3:0]  = 4'd5;
        req_data_sel[3:0]  = 4'd2;
        req_crc_en[0]      = 1'b1;
        req_crc_val[7:0]   = 8'hA5;
        #1;
        check("t1_ready", req_ready, 2'b01);
        step;
        req_valid = 2'b00;
        check("t1_pb_start", pb_start, 1);
        check("t1_pb_addr_in", pb_addr_in, 32'h10);
        check("t1_pb_addr_out", pb_addr_out, 32'h200);
        check("t1_pb_byte_cnt", pb_byte_cnt, 5);
        check("t1_pb_data_sel", pb_data_sel, 2);
        check("t1_pb_crc_en", pb_crc_en, 1);
        check("t1_pb_crc_val", pb_crc_val, 8'hA5);
        check("t1_busy", busy, 1);
        step;
        check("t1_start_one_cycle", pb_start, 0);
        step;
        step;
        step;
        step;
        pb_irq = 1'b1;
        #1;
        check("t1_no_early_done", done_valid, 0);
        step;
        pb_irq = 1'b0;
        check("t1_done_valid", done_valid, 1);
        check("t1_done_id", done_id, 0);
        check("t1_done_err", done_err, 0);
        check("t1_done_timeout", done_timeout, 0);
        step;
        check("t1_done_pulse", done_valid, 0);
        check("t1_idle_busy", busy, 0);
        check("t1_pb_addr_hold", pb_addr_in, 32'h10);

        // pb_irq while idle is ignored
        pb_irq = 1'b1;
        step;
        pb_irq = 1'b0;
        check("irq_idle_busy", busy, 0);
        check("irq_idle_done", done_valid, 0);

        // Both requesters valid continuously from a fresh reset: grants 0,1,0
        reset = 1'b1;
        step;
        reset = 1'b0;
        req_addr_in   = {32'hB1, 32'hA0};
        req_data_sel  = {4'd1, 4'd0};
        req_valid     = 2'b11;
        for (int j = 0; j < 3; j++) begin
            g = j % 2;
            #1;
            check("t2_ready", req_ready, 32'(1) << g);
            step;
            check("t2_pb_start", pb_start, 1);
            check("t2_pb_addr_in", pb_addr_in, (g == 1) ? 32'hB1 : 32'hA0);
            step;
            pb_irq = 1'b1;
            step;
            pb_irq = 1'b0;
            #1;
            check("t2_no_grant_in_done", req_ready, 0);
            check("t2_done_valid", done_valid, 1);
            check("t2_done_id", done_id, g);
            step;
        end
        req_valid = 2'b00;

        // Illegal data_sel on requester 1
        req_data_sel[7:4] = 4'd4;
        req_valid         = 2'b10;
        #1;
        check("t3_ready", req_ready, 2'b10);
        step;
        req_valid = 2'b00;
        check("t3_done_valid", done_valid, 1);
        check("t3_done_err", done_err, 1);
        check("t3_done_id", done_id, 1);
        check("t3_no_start", pb_start, 0);
        check("t3_pb_data_sel", pb_data_sel, 4);
        check("t3_busy", busy, 1);
        step;
        check("t3_done_pulse", done_valid, 0);
        check("t3_err_clear", done_err, 0);
        check("t3_no_start_after", pb_start, 0);
        check("t3_idle", busy, 0);
        req_data_sel[7:4] = 4'd1;

        // sched_en low blocks grants; raising it grants in the same cycle
        sched_en  = 1'b0;
        req_valid = 2'b01;
        for (int j = 0; j < 10; j++) begin
            #1;
            check("t4_blocked_ready", req_ready, 0);
            step;
        end
        check("t4_blocked_busy", busy, 0);
        sched_en = 1'b1;
        #1;
        check("t4_ready", req_ready, 2'b01);
        step;
        req_valid = 2'b00;
        check("t4_pb_start", pb_start, 1);
        check("t4_pb_addr_in", pb_addr_in, 32'hA0);
        step;

        // Reset while waiting for pb_irq aborts the job
        reset = 1'b1;
        step;
        reset = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_pb_start", pb_start, 0);
        check("t5_pb_addr_in", pb_addr_in, 0);
        check("t5_done_valid", done_valid, 0);
        req_valid = 2'b11;
        #1;
        check("t5_ready_req0", req_ready, 2'b01);
        step;
        req_valid = 2'b00;
        check("t5_pb_start2", pb_start, 1);
        step;
        sched_en = 1'b0;
        pb_irq   = 1'b1;
        step;
        pb_irq = 1'b0;
        check("t5_done_with_en_low", done_valid, 1);
        check("t5_done_id", done_id, 0);
        step;
        sched_en = 1'b1;

`ifdef PB_SCHED_TIMEOUT_EN
        // Watchdog expiry after 20 WAIT_IRQ cycles
        req_valid = 2'b01;
        #1;
        check("t6_ready", req_ready, 2'b01);
        step;
        req_valid = 2'b00;
        check("t6_pb_start", pb_start, 1);
        for (int w = 1; w <= 20; w++) begin
            step;
        end
        check("t6_no_early_timeout", done_valid, 0);
        step;
        check("t6_done_valid", done_valid, 1);
        check("t6_done_timeout", done_timeout, 1);
        step;

        // pb_irq on the expiry cycle wins over the watchdog
        req_valid = 2'b01;
        step;
        req_valid = 2'b00;
        for (int w = 1; w <= 20; w++) begin
            step;
        end
        pb_irq = 1'b1;
        step;
        pb_irq = 1'b0;
        check("t6_irq_wins_valid", done_valid, 1);
        check("t6_irq_wins_timeout", done_timeout, 0);
        step;
`else
        check("t6_timeout_tied_low", done_timeout, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
